wb_result_stage: RTL and testbench
==================================

Name: wb_result_stage

Overview:
- Parametrised writeback stage for the RISC-V pipeline; replaces the purely combinational writeback result mux.
- Registers the MEM/WB payload and selects among five result sources.
- Aligns and sign- or zero-extends load data, and waits on a memory read-valid handshake for slow loads.
- Presents a single registered register-file write port with a load-timeout error.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OFFW, $clog2(XLEN/8), width of the load address byte offset.
- LOAD_TIMEOUT, 16, maximum number of cycles spent in WAIT before abort; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; acceptance occurs when in_valid && in_ready.
- in_result_src  in  3  000 ALU, 001 load, 010 PC+4, 011 imm (LUI), 100 PC+imm (AUIPC); 101–111 treated as ALU.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_alu_result  in  XLEN  ALU result.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  decoded immediate.
- in_funct3  in  3  load type.
- in_addr_lo  in  OFFW  low bits of the load address.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- mem_rdata  in  XLEN  raw aligned memory word.
- wb_en  out  1  register-file write strobe.
- wb_rd  out  5  write address.
- wb_data  out  XLEN  write data.
- load_err  out  1  one-cycle pulse when a load times out.

Behaviour:
- Reset: synchronous, active-high.
  - State IDLE; wb_en=0, wb_rd=0, wb_data=0, load_err=0; timeout counter cleared.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-WAIT discards the pending load; no write is issued.
- States: IDLE, WAIT.
  - in_ready = 1 in IDLE, 0 in WAIT. It is a combinational function of state only.
- Non-load accept (IDLE):
  - Latency 1: on the next edge, wb_en = in_reg_write && (in_rd != 0), wb_rd = in_rd, wb_data = the selected result.
  - PC+4 and PC+imm are computed modulo 2^XLEN, with carry discarded.
- Load accept (IDLE):
  - If mem_rvalid=1 in the accept cycle, complete with latency 1, exactly as a non-load.
  - Otherwise latch rd, reg_write, funct3 and addr_lo, then go to WAIT with the counter = 0.
- WAIT:
  - Each cycle with mem_rvalid=1: the next edge writes the extended data and returns the stage to IDLE.
  - Each cycle with mem_rvalid=0: the counter increments.
  - When the counter reaches LOAD_TIMEOUT-1 with mem_rvalid still 0, the next edge goes to IDLE with load_err=1 for one cycle and wb_en=0.
  - mem_rvalid arriving on that same cycle wins: the data is written and there is no error.
- mem_rvalid in IDLE without a load accept is ignored.
- Load extension, where B = byte at offset addr_lo and H = halfword at offset addr_lo with bit 0 ignored:
  - 000 LB: sign-extend B.
  - 100 LBU: zero-extend B.
  - 001 LH: sign-extend H.
  - 101 LHU: zero-extend H.
  - 010 LW:
    - XLEN=32: the full word.
    - XLEN=64: sign-extend the 32-bit word at addr_lo[2].
  - 110 LWU (XLEN=64 only): zero-extend the 32-bit word at addr_lo[2].
  - 011 LD (XLEN=64 only): the full word.
  - Any other code, or a 64-bit-only code when XLEN=32: the full XLEN word, unmodified.
- Output timing: wb_en is high for exactly one cycle per completed instruction. wb_rd and wb_data hold their values when wb_en=0.
- Back-to-back: a new instruction may be accepted on the same edge that a non-load writes back. Throughput is 1 per cycle when there are no waits.

Optional Feature:
- WB_BYPASS_EN defined:
  - Add outputs byp_valid (1), byp_rd (5) and byp_data (XLEN).
  - They hold the most recent write (wb_en, wb_rd, wb_data) for one extra cycle after wb_en, for decode-stage forwarding.
  - byp_valid resets to 0, and is also cleared by a load_err pulse.
- Not defined: the ports are absent and no extra registers exist.

Test Plan:
- ALU and x0:
  - src=000, alu=0x1234_5678, rd=5 -> next cycle wb_en=1, wb_rd=5, wb_data=0x12345678.
  - Same with rd=0 -> wb_en=0.
- Source select:
  - src=010, pc=0xFFFF_FFFC -> wb_data=0x0000_0000 (wrap).
  - src=100, pc=0x100, imm=0x2000 -> 0x2100.
  - src=011, imm=0xABCD_E000 -> 0xABCDE000.
- Load extension:
  - mem_rdata=0x80FF_7F01, addr_lo=3, LB -> 0xFFFFFF80; LBU -> 0x00000080.
  - Same word with addr_lo=2: LH -> 0xFFFF80FF; LHU -> 0x000080FF.
- Wait handshake:
  - Load accepted with mem_rvalid=0; mem_rvalid pulses 3 cycles later -> in_ready=0 for 3 cycles, then one wb_en pulse with the extended data, then in_ready=1.
- Timeout:
  - LOAD_TIMEOUT=4, mem_rvalid never asserts -> load_err pulses once after 4 WAIT cycles, wb_en stays 0, and the next ALU op completes normally.
  - Separately, mem_rvalid on the last WAIT cycle -> write occurs and load_err=0.
- Reset mid-WAIT and bypass:
  - rst asserted while in WAIT -> no wb_en, all outputs 0, in_ready=1 the next cycle.
  - With WB_BYPASS_EN: byp_* mirror the write one cycle after wb_en.

Source files
------------

// File: rtl/wb_result_stage_if.sv
// MEM/WB handshake, load-return and register-file write bundle for wb_result_stage.
// The MEM side and memory drive through 'master'; the writeback stage itself uses 'slave'.
interface wb_result_stage_if #(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN / 8)
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_result_src;
   logic            in_reg_write;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_alu_result;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_imm;
   logic [2:0]      in_funct3;
   logic [OFFW-1:0] in_addr_lo;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            load_err;

   modport master (
      output in_valid, in_result_src, in_reg_write, in_rd, in_alu_result,
             in_pc, in_imm, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
      input  in_ready, wb_en, wb_rd, wb_data, load_err
   );

   modport slave (
      input  in_valid, in_result_src, in_reg_write, in_rd, in_alu_result,
             in_pc, in_imm, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
      output in_ready, wb_en, wb_rd, wb_data, load_err
   );
endinterface

// File: rtl/wb_result_stage.sv
// Registered writeback stage: five-way result select, load extension and a bounded wait for slow loads.
// Define WB_BYPASS_EN to add the byp_valid/byp_rd/byp_data forwarding outputs.
module wb_result_stage #(
   parameter int XLEN         = 32,
   parameter int OFFW         = $clog2(XLEN / 8),
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   wb_result_stage_if.slave bus
`ifdef WB_BYPASS_EN
   ,
   output logic            byp_valid,
   output logic [4:0]      byp_rd,
   output logic [XLEN-1:0] byp_data
`endif
);

   localparam int IDXW = $clog2(XLEN);
   localparam int CNTW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LOAD_TIMEOUT - 1);

   localparam logic [2:0] SRC_LOAD  = 3'b001;
   localparam logic [2:0] SRC_PC4   = 3'b010;
   localparam logic [2:0] SRC_IMM   = 3'b011;
   localparam logic [2:0] SRC_AUIPC = 3'b100;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t          r_state;
   logic [CNTW-1:0] r_cnt;
   logic [4:0]      r_rd;
   logic            r_regWrite;
   logic [2:0]      r_funct3;
   logic [OFFW-1:0] r_addrLo;
   logic            r_wbEn;
   logic [4:0]      r_wbRd;
   logic [XLEN-1:0] r_wbData;
   logic            r_loadErr;

   logic [XLEN-1:0] w_result;
   logic [XLEN-1:0] w_waitData;
   logic            w_slowLoad;

   // Picks the addressed byte/half/word out of the raw memory word and extends it by funct3.
   function automatic logic [XLEN-1:0] extendLoad(
      input logic [2:0]      f3,
      input logic [OFFW-1:0] lo,
      input logic [XLEN-1:0] d
   );
      logic [IDXW-1:0] bIdx;
      logic [IDXW-1:0] hIdx;
      logic [IDXW-1:0] wIdx;
      logic [7:0]      b;
      logic [15:0]     h;
      logic [31:0]     w;
      logic [XLEN-1:0] res;
      bIdx = {lo, 3'b000};
      hIdx = {lo[OFFW-1:1], 4'b0000};
      wIdx = '0;
      if (XLEN == 64) begin
         wIdx = IDXW'({lo[OFFW-1], 5'b00000});
      end
      b = d[bIdx +: 8];
      h = d[hIdx +: 16];
      w = d[wIdx +: 32];
      case (f3)
         3'b000:  res = XLEN'($signed(b));
         3'b100:  res = XLEN'(b);
         3'b001:  res = XLEN'($signed(h));
         3'b101:  res = XLEN'(h);
         3'b010:  res = (XLEN == 64) ? XLEN'($signed(w)) : d;
         3'b110:  res = (XLEN == 64) ? XLEN'(w) : d;
         default: res = d;
      endcase
      return res;
   endfunction

   always_comb begin
      w_result = bus.in_alu_result;
      case (bus.in_result_src)
         SRC_LOAD:  w_result = extendLoad(bus.in_funct3, bus.in_addr_lo, bus.mem_rdata);
         SRC_PC4:   w_result = bus.in_pc + XLEN'(4);
         SRC_IMM:   w_result = bus.in_imm;
         SRC_AUIPC: w_result = bus.in_pc + bus.in_imm;
         default:   w_result = bus.in_alu_result;
      endcase
   end

   assign w_waitData = extendLoad(r_funct3, r_addrLo, bus.mem_rdata);
   assign w_slowLoad = (bus.in_result_src == SRC_LOAD) && !bus.mem_rvalid;

   assign bus.in_ready = (r_state == IDLE);
   assign bus.wb_en    = r_wbEn;
   assign bus.wb_rd    = r_wbRd;
   assign bus.wb_data  = r_wbData;
   assign bus.load_err = r_loadErr;

   // wb_rd/wb_data only move on a real write, so they hold through x0 writes and idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rd       <= '0;
         r_regWrite <= 1'b0;
         r_funct3   <= '0;
         r_addrLo   <= '0;
         r_wbEn     <= 1'b0;
         r_wbRd     <= '0;
         r_wbData   <= '0;
         r_loadErr  <= 1'b0;
      end else begin
         r_wbEn    <= 1'b0;
         r_loadErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (w_slowLoad) begin
                     r_rd       <= bus.in_rd;
                     r_regWrite <= bus.in_reg_write;
                     r_funct3   <= bus.in_funct3;
                     r_addrLo   <= bus.in_addr_lo;
                     r_cnt      <= '0;
                     r_state    <= WAIT;
                  end else if (bus.in_reg_write && (bus.in_rd != 5'd0)) begin
                     r_wbEn   <= 1'b1;
                     r_wbRd   <= bus.in_rd;
                     r_wbData <= w_result;
                  end
               end
            end
            WAIT: begin
               // A late rvalid on the final allowed cycle still beats the timeout.
               if (bus.mem_rvalid) begin
                  r_state <= IDLE;
                  if (r_regWrite && (r_rd != 5'd0)) begin
                     r_wbEn   <= 1'b1;
                     r_wbRd   <= r_rd;
                     r_wbData <= w_waitData;
                  end
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= IDLE;
                  r_loadErr <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef WB_BYPASS_EN
   logic            r_bypValid;
   logic [4:0]      r_bypRd;
   logic [XLEN-1:0] r_bypData;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bypValid <= 1'b0;
         r_bypRd    <= '0;
         r_bypData  <= '0;
      end else begin
         r_bypValid <= r_wbEn && !r_loadErr;
         r_bypRd    <= r_wbRd;
         r_bypData  <= r_wbData;
      end
   end

   assign byp_valid = r_bypValid;
   assign byp_rd    = r_bypRd;
   assign byp_data  = r_bypData;
`endif

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage (XLEN=32, LOAD_TIMEOUT=4) with a cycle-level reference model.
module tb_wb_result_stage;
   localparam int XLEN = 32;
   localparam int LT   = 4;

   logic clk;
   logic rst;

   wb_result_stage_if #(.XLEN(XLEN)) bus ();

`ifdef WB_BYPASS_EN
   logic        byp_valid;
   logic [4:0]  byp_rd;
   logic [31:0] byp_data;
`endif

   wb_result_stage #(.XLEN(XLEN), .LOAD_TIMEOUT(LT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef WB_BYPASS_EN
      ,
      .byp_valid(byp_valid),
      .byp_rd(byp_rd),
      .byp_data(byp_data)
`endif
   );

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state
   bit          modelLive = 0;
   bit          pending   = 0;
   int          waited    = 0;
   logic [4:0]  pRd;
   logic        pWe;
   logic [2:0]  pF3;
   logic [1:0]  pLo;
   logic        mEn  = 0;
   logic        mErr = 0;
   logic [4:0]  mRd  = 0;
   logic [31:0] mData = 0;
   logic        bypV  = 0;
   logic [4:0]  bypRd = 0;
   logic [31:0] bypD  = 0;

   localparam logic [31:0] W = 32'h80FF_7F01;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Load result from shifts and masks on the raw word.
   function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
      logic [31:0] b;
      logic [31:0] h;
      b = (d >> (8 * lo)) & 32'hFF;
      h = (d >> (16 * (lo >> 1))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] refResult(input logic [2:0] src, input logic [31:0] alu, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [31:0] ld);
      case (src)
         3'd1:    return ld;
         3'd2:    return pc + 32'd4;
         3'd3:    return imm;
         3'd4:    return pc + imm;
         default: return alu;
      endcase
   endfunction

   task automatic modelRetire(input logic we, input logic [4:0] rd, input logic [31:0] data);
      if (we && rd != 5'd0) begin
         mEn   = 1'b1;
         mRd   = rd;
         mData = data;
      end
   endtask

   // Instruction-level model: a pending slow load counts its waited cycles until data or the limit.
   always @(posedge clk) begin
      if (rst) begin
         modelLive = 1;
         pending = 0;
         waited = 0;
         mEn = 0; mErr = 0; mRd = 0; mData = 0;
         bypV = 0; bypRd = 0; bypD = 0;
      end else begin
         bypV  = mEn;
         bypRd = mRd;
         bypD  = mData;
         mEn  = 0;
         mErr = 0;
         if (pending) begin
            if (bus.mem_rvalid) begin
               modelRetire(pWe, pRd, refLoad(pF3, pLo, bus.mem_rdata));
               pending = 0;
            end else begin
               waited++;
               if (waited == LT) begin
                  pending = 0;
                  mErr = 1;
               end
            end
         end else if (bus.in_valid) begin
            if (bus.in_result_src == 3'd1 && !bus.mem_rvalid) begin
               pending = 1;
               waited = 0;
               pRd = bus.in_rd;
               pWe = bus.in_reg_write;
               pF3 = bus.in_funct3;
               pLo = bus.in_addr_lo;
            end else begin
               modelRetire(bus.in_reg_write, bus.in_rd,
                  refResult(bus.in_result_src, bus.in_alu_result, bus.in_pc, bus.in_imm,
                            refLoad(bus.in_funct3, bus.in_addr_lo, bus.mem_rdata)));
            end
         end
      end
   end

   task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model-vs-DUT comparison on every falling edge once reset has been seen.
   always @(negedge clk) begin
      if (modelLive) begin
         compareVal("model wb_en", {63'd0, bus.wb_en}, {63'd0, mEn});
         compareVal("model wb_rd", {59'd0, bus.wb_rd}, {59'd0, mRd});
         compareVal("model wb_data", {32'd0, bus.wb_data}, {32'd0, mData});
         compareVal("model load_err", {63'd0, bus.load_err}, {63'd0, mErr});
         compareVal("model in_ready", {63'd0, bus.in_ready}, {63'd0, !pending});
`ifdef WB_BYPASS_EN
         compareVal("model byp_valid", {63'd0, byp_valid}, {63'd0, bypV});
         compareVal("model byp_rd", {59'd0, byp_rd}, {59'd0, bypRd});
         compareVal("model byp_data", {32'd0, byp_data}, {32'd0, bypD});
`endif
      end
   end

   task automatic applyStimulus(input logic v, input logic [2:0] src, input logic we, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [2:0] f3, input logic [1:0] lo, input logic rv, input logic [31:0] rdata);
      bus.in_valid      = v;
      bus.in_result_src = src;
      bus.in_reg_write  = we;
      bus.in_rd         = rd;
      bus.in_alu_result = alu;
      bus.in_pc         = pc;
      bus.in_imm        = imm;
      bus.in_funct3     = f3;
      bus.in_addr_lo    = lo;
      bus.mem_rvalid    = rv;
      bus.mem_rdata     = rdata;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rv, input logic [31:0] rdata);
      applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, rv, rdata);
   endtask

   task automatic loadOp(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd, input logic rv, input logic [31:0] rdata);
      applyStimulus(1'b1, 3'd1, 1'b1, rd, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, f3, lo, rv, rdata);
   endtask

   task automatic checkOutput(input string name, input logic en, input logic err, input logic ready);
      compareVal({name, " wb_en"}, {63'd0, bus.wb_en}, {63'd0, en});
      compareVal({name, " load_err"}, {63'd0, bus.load_err}, {63'd0, err});
      compareVal({name, " in_ready"}, {63'd0, bus.in_ready}, {63'd0, ready});
   endtask

   task automatic checkData(input string name, input logic [4:0] rd, input logic [31:0] data);
      compareVal({name, " wb_rd"}, {59'd0, bus.wb_rd}, {59'd0, rd});
      compareVal({name, " wb_data"}, {32'd0, bus.wb_data}, {32'd0, data});
   endtask

   initial begin
      rst = 1'b1;
      idle(1'b0, 32'h0);
      idle(1'b0, 32'h0);
      checkOutput("reset", 1'b0, 1'b0, 1'b1);
      checkData("reset", 5'd0, 32'h0);
      rst = 1'b0;

      applyStimulus(1'b1, 3'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h40, 32'h8, 3'd0, 2'd0, 1'b0, 32'h0);
      checkOutput("alu", 1'b1, 1'b0, 1'b1);
      checkData("alu", 5'd5, 32'h1234_5678);
      applyStimulus(1'b1, 3'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h40, 32'h8, 3'd0, 2'd0, 1'b0, 32'h0);
      checkOutput("x0", 1'b0, 1'b0, 1'b1);
      checkData("x0 hold", 5'd5, 32'h1234_5678);
      applyStimulus(1'b1, 3'd2, 1'b1, 5'd1, 32'h7, 32'hFFFF_FFFC, 32'h8, 3'd0, 2'd0, 1'b0, 32'h0);
      checkData("pc4 wrap", 5'd1, 32'h0);
      applyStimulus(1'b1, 3'd4, 1'b1, 5'd2, 32'h7, 32'h100, 32'h2000, 3'd0, 2'd0, 1'b0, 32'h0);
      checkData("auipc", 5'd2, 32'h2100);
      applyStimulus(1'b1, 3'd3, 1'b1, 5'd3, 32'h7, 32'h100, 32'hABCD_E000, 3'd0, 2'd0, 1'b0, 32'h0);
      checkData("lui", 5'd3, 32'hABCD_E000);
      applyStimulus(1'b1, 3'd5, 1'b1, 5'd4, 32'h55, 32'h100, 32'h200, 3'd0, 2'd0, 1'b0, 32'h0);
      checkData("src101", 5'd4, 32'h55);

      loadOp(3'd0, 2'd3, 5'd6, 1'b1, W); checkData("lb", 5'd6, 32'hFFFF_FF80);
      loadOp(3'd4, 2'd3, 5'd6, 1'b1, W); checkData("lbu", 5'd6, 32'h0000_0080);
      loadOp(3'd1, 2'd2, 5'd6, 1'b1, W); checkData("lh", 5'd6, 32'hFFFF_80FF);
      loadOp(3'd5, 2'd2, 5'd6, 1'b1, W); checkData("lhu", 5'd6, 32'h0000_80FF);
      loadOp(3'd1, 2'd3, 5'd6, 1'b1, W); checkData("lh bit0", 5'd6, 32'hFFFF_80FF);
      loadOp(3'd0, 2'd0, 5'd6, 1'b1, W); checkData("lb pos", 5'd6, 32'h0000_0001);
      loadOp(3'd1, 2'd0, 5'd6, 1'b1, W); checkData("lh pos", 5'd6, 32'h0000_7F01);
      loadOp(3'd2, 2'd1, 5'd6, 1'b1, W); checkData("lw", 5'd6, 32'h80FF_7F01);
      loadOp(3'd6, 2'd1, 5'd6, 1'b1, 32'h1357_9BDF); checkData("lwu32", 5'd6, 32'h1357_9BDF);
      loadOp(3'd3, 2'd0, 5'd6, 1'b1, W); checkData("ld32", 5'd6, 32'h80FF_7F01);
      idle(1'b1, 32'h5555_5555);
      checkOutput("idle rvalid", 1'b0, 1'b0, 1'b1);

      loadOp(3'd0, 2'd1, 5'd7, 1'b0, 32'h0);
      checkOutput("wait 1", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b1, 5'd11, 32'h99, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
      checkOutput("wait 2", 1'b0, 1'b0, 1'b0);
      idle(1'b0, 32'h0);
      checkOutput("wait 3", 1'b0, 1'b0, 1'b0);
      idle(1'b1, W);
      checkOutput("wait done", 1'b1, 1'b0, 1'b1);
      checkData("wait done", 5'd7, 32'h0000_007F);
      idle(1'b0, 32'h0);
      checkOutput("after wait", 1'b0, 1'b0, 1'b1);

      loadOp(3'd4, 2'd0, 5'd8, 1'b0, 32'h0);
      for (int i = 0; i < LT - 1; i++) begin
         idle(1'b0, 32'h0);
         checkOutput("timeout pend", 1'b0, 1'b0, 1'b0);
      end
      idle(1'b0, 32'h0);
      checkOutput("timeout", 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 3'd0, 1'b1, 5'd12, 32'h0000_CAFE, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
      checkOutput("post timeout", 1'b1, 1'b0, 1'b1);
      checkData("post timeout", 5'd12, 32'h0000_CAFE);

      loadOp(3'd5, 2'd2, 5'd9, 1'b0, 32'h0);
      for (int i = 0; i < LT - 1; i++) begin
         idle(1'b0, 32'h0);
      end
      idle(1'b1, W);
      checkOutput("last cycle", 1'b1, 1'b0, 1'b1);
      checkData("last cycle", 5'd9, 32'h0000_80FF);

      loadOp(3'd0, 2'd1, 5'd10, 1'b0, 32'h0);
      idle(1'b0, 32'h0);
      rst = 1'b1;
      idle(1'b1, W);
      checkOutput("reset wait", 1'b0, 1'b0, 1'b1);
      checkData("reset wait", 5'd0, 32'h0);
      rst = 1'b0;
      idle(1'b1, W);
      checkOutput("after reset", 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd0, 1'b1, 5'd13, 32'h0F0F, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
      checkData("final alu", 5'd13, 32'h0F0F);
      idle(1'b0, 32'h0);
      idle(1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
